// File: rtl/cpu_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cpu_ctrl_pkg
// Shared definitions for the hardwired control sequencer:
//   - state_t        : sequencer step (IDLE, fetch T0-T2, execute T3-T6, HALTED)
//   - instr_class_t  : execute-sequence family an opcode belongs to
//   - OP_*           : 5-bit opcode constants
//   - IR field positions (opcode [31:27], Ra [26:23], Rb [22:19], Rc [18:15])
//   - classify()     : opcode -> instruction class
// -----------------------------------------------------------------------------
package cpu_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_T0,
      ST_T1,
      ST_T2,
      ST_T3,
      ST_T4,
      ST_T5,
      ST_T6,
      ST_HALTED
   } state_t;

   typedef enum logic [2:0] {
      CLS_ALU3,
      CLS_UNARY,
      CLS_MULDIV,
      CLS_NOP,
      CLS_HALT,
      CLS_ILLEGAL
   } instr_class_t;

   localparam int OPC_W   = 5;
   localparam int REG_W   = 4;
   localparam int OPC_LSB = 27;
   localparam int RA_LSB  = 23;
   localparam int RB_LSB  = 19;
   localparam int RC_LSB  = 15;

   localparam logic [OPC_W-1:0] OP_ADD  = 5'b00011;
   localparam logic [OPC_W-1:0] OP_SUB  = 5'b00100;
   localparam logic [OPC_W-1:0] OP_AND  = 5'b00101;
   localparam logic [OPC_W-1:0] OP_OR   = 5'b00110;
   localparam logic [OPC_W-1:0] OP_ROR  = 5'b00111;
   localparam logic [OPC_W-1:0] OP_ROL  = 5'b01000;
   localparam logic [OPC_W-1:0] OP_SHR  = 5'b01001;
   localparam logic [OPC_W-1:0] OP_SHRA = 5'b01010;
   localparam logic [OPC_W-1:0] OP_SHL  = 5'b01011;
   localparam logic [OPC_W-1:0] OP_MUL  = 5'b01111;
   localparam logic [OPC_W-1:0] OP_DIV  = 5'b10000;
   localparam logic [OPC_W-1:0] OP_NEG  = 5'b10001;
   localparam logic [OPC_W-1:0] OP_NOT  = 5'b10010;
   localparam logic [OPC_W-1:0] OP_NOP  = 5'b11010;
   localparam logic [OPC_W-1:0] OP_HALT = 5'b11011;

   function automatic instr_class_t classify(input logic [OPC_W-1:0] op);
      instr_class_t cls;
      case (op)
         OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR,
         OP_ROL, OP_SHR, OP_SHRA, OP_SHL:         cls = CLS_ALU3;
         OP_NEG, OP_NOT:                          cls = CLS_UNARY;
         OP_MUL, OP_DIV:                          cls = CLS_MULDIV;
         OP_NOP:                                  cls = CLS_NOP;
         OP_HALT:                                 cls = CLS_HALT;
         default:                                 cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/ir_decoder.sv
// -----------------------------------------------------------------------------
// ir_decoder
// Purely combinational instruction decode for the control sequencer.
// Ports:
//   i_ir      in  32       IR contents
//   o_opcode  out 5        opcode field, forwarded as the ALU operation
//   o_cls     out class    execute-sequence family of the opcode
//   o_ra_oh   out NUM_GPR  one-hot of the Ra field
//   o_rb_oh   out NUM_GPR  one-hot of the Rb field
//   o_rc_oh   out NUM_GPR  one-hot of the Rc field
// -----------------------------------------------------------------------------
module ir_decoder
   import cpu_ctrl_pkg::*;
#(
   parameter int NUM_GPR = 16
) (
   input  logic [31:0]        i_ir,
   output logic [OPC_W-1:0]   o_opcode,
   output instr_class_t       o_cls,
   output logic [NUM_GPR-1:0] o_ra_oh,
   output logic [NUM_GPR-1:0] o_rb_oh,
   output logic [NUM_GPR-1:0] o_rc_oh
);

   logic [REG_W-1:0] w_ra;
   logic [REG_W-1:0] w_rb;
   logic [REG_W-1:0] w_rc;
   logic             w_unused_ir;

   assign o_opcode = i_ir[OPC_LSB +: OPC_W];
   assign w_ra     = i_ir[RA_LSB +: REG_W];
   assign w_rb     = i_ir[RB_LSB +: REG_W];
   assign w_rc     = i_ir[RC_LSB +: REG_W];
   // Immediate/address bits below Rc do not influence sequencing.
   assign w_unused_ir = ^i_ir[RC_LSB-1:0];

   assign o_cls = classify(o_opcode);

   always_comb begin
      o_ra_oh = '0;
      o_rb_oh = '0;
      o_rc_oh = '0;
      o_ra_oh[w_ra] = 1'b1;
      o_rb_oh[w_rb] = 1'b1;
      o_rc_oh[w_rc] = 1'b1;
   end

endmodule

// File: rtl/control_sequencer.sv
// -----------------------------------------------------------------------------
// control_sequencer
// Hardwired micro-sequencer for the single-bus datapath. Steps fetch (T0-T2)
// and execute (T3-T6) and drives registered, one-cycle-wide control strobes.
// Ports:
//   clock, clear          clock; asynchronous active-high reset
//   run                   1 = keep fetching; 0 = stop at next instruction boundary
//   mem_ready             memory read data valid (stretches T1 while low)
//   ir[31:0]              IR contents
//   PCout/MDRout/ZLowout/ZHighout, Rout[NUM_GPR]   bus-source selects (one per cycle)
//   Rin[NUM_GPR]          one-hot GPR load enable
//   PC_enable, IncPC, MAR_enable, MDR_enable, Read, IR_enable, Y_enable,
//   Z_low_enable, Z_high_enable, LO_enable, HI_enable            load strobes
//   operation[4:0]        ALU opcode, zero whenever Z enables are zero
//   busy, halted, illegal status; illegal is sticky until clear
//   instr_count[CNT_W]    retired instructions (halt/illegal excluded), wraps
// Every output is a register loaded with the controls of the step being
// entered, so each control set is stable for exactly one full cycle.
// The T3 controls are therefore formed from ir at the T2->T3 edge; the decoded
// class and register fields are captured at that same edge and used for T4-T6.
// -----------------------------------------------------------------------------
module control_sequencer
   import cpu_ctrl_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int NUM_GPR = 16
) (
   input  logic               clock,
   input  logic               clear,
   input  logic               run,
   input  logic               mem_ready,
   input  logic [31:0]        ir,
   output logic               PCout,
   output logic               MDRout,
   output logic               ZLowout,
   output logic               ZHighout,
   output logic [NUM_GPR-1:0] Rout,
   output logic [NUM_GPR-1:0] Rin,
   output logic               PC_enable,
   output logic               IncPC,
   output logic               MAR_enable,
   output logic               MDR_enable,
   output logic               Read,
   output logic               IR_enable,
   output logic               Y_enable,
   output logic               Z_low_enable,
   output logic               Z_high_enable,
   output logic               LO_enable,
   output logic               HI_enable,
   output logic [OPC_W-1:0]   operation,
   output logic               busy,
   output logic               halted,
   output logic               illegal,
   output logic [CNT_W-1:0]   instr_count
);

   state_t                r_state;
   instr_class_t          r_cls;
   logic [OPC_W-1:0]      r_op;
   logic [NUM_GPR-1:0]    r_ra_oh;
   logic [NUM_GPR-1:0]    r_rb_oh;
   logic [NUM_GPR-1:0]    r_rc_oh;

   instr_class_t          w_cls;
   logic [OPC_W-1:0]      w_opcode;
   logic [NUM_GPR-1:0]    w_ra_oh;
   logic [NUM_GPR-1:0]    w_rb_oh;
   logic [NUM_GPR-1:0]    w_rc_oh;
   logic                  w_done;

   ir_decoder #(
      .NUM_GPR (NUM_GPR)
   ) u_ir_decoder (
      .i_ir     (ir),
      .o_opcode (w_opcode),
      .o_cls    (w_cls),
      .o_ra_oh  (w_ra_oh),
      .o_rb_oh  (w_rb_oh),
      .o_rc_oh  (w_rc_oh)
   );

   // Last execute step of an instruction that retires.
   assign w_done = ((r_state == ST_T3) && (r_cls == CLS_NOP))   ||
                   ((r_state == ST_T4) && (r_cls == CLS_UNARY)) ||
                   ((r_state == ST_T5) && (r_cls == CLS_ALU3))  ||
                    (r_state == ST_T6);

   // Decoded instruction held for the remaining execute steps.
   always_ff @(posedge clock) begin
      if (r_state == ST_T2) begin
         r_cls   <= w_cls;
         r_op    <= w_opcode;
         r_ra_oh <= w_ra_oh;
         r_rb_oh <= w_rb_oh;
         r_rc_oh <= w_rc_oh;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state       <= ST_IDLE;
         PCout         <= 1'b0;
         MDRout        <= 1'b0;
         ZLowout       <= 1'b0;
         ZHighout      <= 1'b0;
         Rout          <= '0;
         Rin           <= '0;
         PC_enable     <= 1'b0;
         IncPC         <= 1'b0;
         MAR_enable    <= 1'b0;
         MDR_enable    <= 1'b0;
         Read          <= 1'b0;
         IR_enable     <= 1'b0;
         Y_enable      <= 1'b0;
         Z_low_enable  <= 1'b0;
         Z_high_enable <= 1'b0;
         LO_enable     <= 1'b0;
         HI_enable     <= 1'b0;
         operation     <= '0;
         busy          <= 1'b0;
         halted        <= 1'b0;
         illegal       <= 1'b0;
         instr_count   <= '0;
      end else begin
         // Every strobe drops unless the step being entered asserts it.
         PCout         <= 1'b0;
         MDRout        <= 1'b0;
         ZLowout       <= 1'b0;
         ZHighout      <= 1'b0;
         Rout          <= '0;
         Rin           <= '0;
         PC_enable     <= 1'b0;
         IncPC         <= 1'b0;
         MAR_enable    <= 1'b0;
         MDR_enable    <= 1'b0;
         Read          <= 1'b0;
         IR_enable     <= 1'b0;
         Y_enable      <= 1'b0;
         Z_low_enable  <= 1'b0;
         Z_high_enable <= 1'b0;
         LO_enable     <= 1'b0;
         HI_enable     <= 1'b0;
         operation     <= '0;
         busy          <= 1'b0;
         halted        <= 1'b0;

         if (w_done) begin
            // run is only looked at here, so a mid-instruction drop is ignored.
            instr_count <= instr_count + CNT_W'(1);
            if (run) begin
               r_state    <= ST_T0;
               PCout      <= 1'b1;
               MAR_enable <= 1'b1;
               PC_enable  <= 1'b1;
               IncPC      <= 1'b1;
               busy       <= 1'b1;
            end else begin
               r_state <= ST_IDLE;
            end
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (run) begin
                     r_state    <= ST_T0;
                     PCout      <= 1'b1;
                     MAR_enable <= 1'b1;
                     PC_enable  <= 1'b1;
                     IncPC      <= 1'b1;
                     busy       <= 1'b1;
                  end
               end
               ST_T0: begin
                  r_state    <= ST_T1;
                  Read       <= 1'b1;
                  MDR_enable <= 1'b1;
                  busy       <= 1'b1;
               end
               ST_T1: begin
                  busy <= 1'b1;
                  if (mem_ready) begin
                     r_state   <= ST_T2;
                     MDRout    <= 1'b1;
                     IR_enable <= 1'b1;
                  end else begin
                     Read       <= 1'b1;
                     MDR_enable <= 1'b1;
                  end
               end
               ST_T2: begin
                  r_state <= ST_T3;
                  busy    <= 1'b1;
                  case (w_cls)
                     CLS_ALU3: begin
                        Rout     <= w_rb_oh;
                        Y_enable <= 1'b1;
                     end
                     CLS_UNARY: begin
                        Rout          <= w_rb_oh;
                        operation     <= w_opcode;
                        Z_low_enable  <= 1'b1;
                        Z_high_enable <= 1'b1;
                     end
                     CLS_MULDIV: begin
                        Rout     <= w_ra_oh;
                        Y_enable <= 1'b1;
                     end
                     // nop/halt/illegal spend T3 with no datapath activity.
                     default: ;
                  endcase
               end
               ST_T3: begin
                  case (r_cls)
                     CLS_ALU3: begin
                        r_state       <= ST_T4;
                        busy          <= 1'b1;
                        Rout          <= r_rc_oh;
                        operation     <= r_op;
                        Z_low_enable  <= 1'b1;
                        Z_high_enable <= 1'b1;
                     end
                     CLS_UNARY: begin
                        r_state <= ST_T4;
                        busy    <= 1'b1;
                        ZLowout <= 1'b1;
                        Rin     <= r_ra_oh;
                     end
                     CLS_MULDIV: begin
                        r_state       <= ST_T4;
                        busy          <= 1'b1;
                        Rout          <= r_rb_oh;
                        operation     <= r_op;
                        Z_low_enable  <= 1'b1;
                        Z_high_enable <= 1'b1;
                     end
                     CLS_HALT: begin
                        r_state <= ST_HALTED;
                        halted  <= 1'b1;
                     end
                     // CLS_NOP retires through w_done; only illegal lands here.
                     default: begin
                        r_state <= ST_HALTED;
                        halted  <= 1'b1;
                        illegal <= 1'b1;
                     end
                  endcase
               end
               ST_T4: begin
                  r_state <= ST_T5;
                  busy    <= 1'b1;
                  ZLowout <= 1'b1;
                  if (r_cls == CLS_MULDIV) begin
                     LO_enable <= 1'b1;
                  end else begin
                     Rin <= r_ra_oh;
                  end
               end
               ST_T5: begin
                  // Only mul/div still has a step left here.
                  r_state   <= ST_T6;
                  busy      <= 1'b1;
                  ZHighout  <= 1'b1;
                  HI_enable <= 1'b1;
               end
               ST_HALTED: begin
                  halted <= 1'b1;
               end
               default: begin
                  r_state <= ST_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_control_sequencer.sv
`timescale 1ns/1ps
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear;
   logic        run;
   logic        mem_ready;
   logic [31:0] ir;

   logic        PCout, MDRout, ZLowout, ZHighout;
   logic [15:0] Rout, Rin;
   logic        PC_enable, IncPC, MAR_enable, MDR_enable, Read, IR_enable;
   logic        Y_enable, Z_low_enable, Z_high_enable, LO_enable, HI_enable;
   logic [4:0]  operation;
   logic        busy, halted, illegal;
   logic [15:0] instr_count;

   control_sequencer #(
      .CNT_W   (16),
      .NUM_GPR (16)
   ) dut (
      .clock         (clock),
      .clear         (clear),
      .run           (run),
      .mem_ready     (mem_ready),
      .ir            (ir),
      .PCout         (PCout),
      .MDRout        (MDRout),
      .ZLowout       (ZLowout),
      .ZHighout      (ZHighout),
      .Rout          (Rout),
      .Rin           (Rin),
      .PC_enable     (PC_enable),
      .IncPC         (IncPC),
      .MAR_enable    (MAR_enable),
      .MDR_enable    (MDR_enable),
      .Read          (Read),
      .IR_enable     (IR_enable),
      .Y_enable      (Y_enable),
      .Z_low_enable  (Z_low_enable),
      .Z_high_enable (Z_high_enable),
      .LO_enable     (LO_enable),
      .HI_enable     (HI_enable),
      .operation     (operation),
      .busy          (busy),
      .halted        (halted),
      .illegal       (illegal),
      .instr_count   (instr_count)
   );

   always #5 clock = ~clock;

   // One cycle's worth of controls and status.
   typedef struct packed {
      logic        pco, mdro, zlo, zho;
      logic [15:0] rout, rin;
      logic        pce, inc, mare, mdre, rd, ire, ye, zle, zhe, loe, hie;
      logic [4:0]  op;
      logic        busy, halted, illegal;
   } ctl_t;

   ctl_t        exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_count = '0;
   bit          chained   = 1'b0;

   logic [4:0] legal_ops [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                  5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                  5'b10000, 5'b10001, 5'b10010, 5'b11010};

   function automatic ctl_t observe();
      ctl_t o;
      o.pco = PCout;       o.mdro = MDRout;    o.zlo = ZLowout;    o.zho = ZHighout;
      o.rout = Rout;       o.rin = Rin;
      o.pce = PC_enable;   o.inc = IncPC;      o.mare = MAR_enable; o.mdre = MDR_enable;
      o.rd = Read;         o.ire = IR_enable;  o.ye = Y_enable;
      o.zle = Z_low_enable; o.zhe = Z_high_enable; o.loe = LO_enable; o.hie = HI_enable;
      o.op = operation;    o.busy = busy;      o.halted = halted;  o.illegal = illegal;
      return o;
   endfunction

   function automatic logic [15:0] oh(input logic [3:0] r);
      return 16'h0001 << r;
   endfunction

   task automatic chk_ctl(input string tag, input int cyc, input ctl_t expv);
      ctl_t obs;
      obs = observe();
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s cycle %0d: observed %h required %h", tag, cyc, obs, expv);
      end
   endtask

   task automatic chk_cnt(input string tag);
      checks++;
      assert (instr_count === exp_count) else begin
         failures++;
         $error("FAIL %s: instr_count observed %0d required %0d", tag, instr_count, exp_count);
      end
   endtask

   // Expected per-cycle controls of one instruction, from T0 onward.
   task automatic build(input logic [31:0] iw, input int w, output bit stops);
      ctl_t c;
      logic [4:0] op;
      logic [3:0] ra, rb, rc;
      op = iw[31:27]; ra = iw[26:23]; rb = iw[22:19]; rc = iw[18:15];
      exp_q.delete();
      stops = 1'b0;
      c = '0; c.busy = 1; c.pco = 1; c.mare = 1; c.pce = 1; c.inc = 1; exp_q.push_back(c);
      for (int i = 0; i <= w; i++) begin
         c = '0; c.busy = 1; c.rd = 1; c.mdre = 1; exp_q.push_back(c);
      end
      c = '0; c.busy = 1; c.mdro = 1; c.ire = 1; exp_q.push_back(c);
      case (op)
         5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
         5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
            c = '0; c.busy = 1; c.rout = oh(rb); c.ye = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.rout = oh(rc); c.op = op; c.zle = 1; c.zhe = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.zlo = 1; c.rin = oh(ra); exp_q.push_back(c);
         end
         5'b10001, 5'b10010: begin
            c = '0; c.busy = 1; c.rout = oh(rb); c.op = op; c.zle = 1; c.zhe = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.zlo = 1; c.rin = oh(ra); exp_q.push_back(c);
         end
         5'b01111, 5'b10000: begin
            c = '0; c.busy = 1; c.rout = oh(ra); c.ye = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.rout = oh(rb); c.op = op; c.zle = 1; c.zhe = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.zlo = 1; c.loe = 1; exp_q.push_back(c);
            c = '0; c.busy = 1; c.zho = 1; c.hie = 1; exp_q.push_back(c);
         end
         5'b11010: begin
            c = '0; c.busy = 1; exp_q.push_back(c);
         end
         default: begin
            c = '0; c.busy = 1; exp_q.push_back(c);
            c = '0; c.halted = 1; c.illegal = (op != 5'b11011); exp_q.push_back(c);
            stops = 1'b1;
         end
      endcase
   endtask

   // Runs one instruction; called at a negedge. w = T1 wait cycles,
   // keep = run held high at completion, abort_at = cycle index to clear at (-1: none).
   task automatic exec(input string tag, input logic [31:0] iw, input int w,
                       input bit keep, input int abort_at);
      bit   stops;
      int   last;
      ctl_t zero;
      zero = '0;
      build(iw, w, stops);
      last = exp_q.size() - 1;
      ir = iw;
      if (!chained) begin
         run = 1'b1;
         mem_ready = 1'($urandom_range(0, 1));
      end
      for (int k = 0; k <= last; k++) begin
         @(negedge clock);
         chk_ctl(tag, k, exp_q[k]);
         if (k == 0) chk_cnt({tag, "_cnt"});
         if (k == abort_at) begin
            #2 clear = 1'b1;
            exp_count = '0;
            #1 chk_ctl({tag, "_clr_async"}, k, zero);
            chk_cnt({tag, "_clr_cnt"});
            @(negedge clock);
            chk_ctl({tag, "_clr_next"}, k + 1, zero);
            run = 1'b0;
            clear = 1'b0;
            chained = 1'b0;
            return;
         end
         if (k >= 1 && k <= w)  mem_ready = 1'b0;
         else if (k == w + 1)   mem_ready = 1'b1;
         else                   mem_ready = 1'($urandom_range(0, 1));
         run = (k == last) ? keep : 1'($urandom_range(0, 1));
      end
      if (stops) begin
         chained = 1'b0;
      end else begin
         exp_count = exp_count + 16'd1;
         chained = keep;
         if (!keep) begin
            @(negedge clock);
            chk_ctl({tag, "_idle"}, last + 1, zero);
            chk_cnt({tag, "_idle_cnt"});
         end
      end
   endtask

   task automatic halted_hold(input string tag, input bit ill);
      ctl_t h;
      h = '0; h.halted = 1; h.illegal = ill;
      for (int i = 0; i < 6; i++) begin
         run = i[0];
         mem_ready = 1'($urandom_range(0, 1));
         @(negedge clock);
         chk_ctl(tag, i, h);
      end
      chk_cnt({tag, "_cnt"});
      clear = 1'b1;
      exp_count = '0;
      @(negedge clock);
      chk_ctl({tag, "_clear"}, 0, '0);
      chk_cnt({tag, "_clear_cnt"});
      run = 1'b0;
      clear = 1'b0;
      chained = 1'b0;
      @(negedge clock);
      chk_ctl({tag, "_idle"}, 0, '0);
   endtask

   initial begin
      logic [31:0] iw;
      ctl_t zero;
      zero = '0;
      clear = 1'b1;
      run = 1'b0;
      mem_ready = 1'b0;
      ir = '0;
      repeat (2) @(negedge clock);
      chk_ctl("reset", 0, zero);
      chk_cnt("reset_cnt");
      clear = 1'b0;
      @(negedge clock);
      chk_ctl("idle_hold", 0, zero);

      // add R5,R2,R4
      exec("add", {5'b00011, 4'd5, 4'd2, 4'd4, 15'h0}, 0, 1'b0, -1);
      exec("add_wait", {5'b00011, 4'd5, 4'd2, 4'd4, 15'h0}, 3, 1'b0, -1);
      // neg R0,R7
      exec("neg", {5'b10001, 4'd0, 4'd7, 4'd0, 15'h0}, 0, 1'b0, -1);
      // mul R3,R6 then chained nop and register aliasing
      exec("mul", {5'b01111, 4'd3, 4'd6, 4'd0, 15'h1234}, 0, 1'b1, -1);
      exec("nop", {5'b11010, 27'h5a5a5a5}, 1, 1'b1, -1);
      exec("alias", {5'b00100, 4'd9, 4'd9, 4'd9, 15'h0}, 0, 1'b0, -1);

      for (int n = 0; n < 24; n++) begin
         iw = $urandom();
         iw[31:27] = legal_ops[$urandom_range(0, 13)];
         exec("rand", iw, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), -1);
      end

      // clear during T4 of an add
      exec("add_clr", {5'b00011, 4'd5, 4'd2, 4'd4, 15'h0}, 0, 1'b0, 4);
      exec("after_clr", {5'b00101, 4'd1, 4'd14, 4'd15, 15'h0}, 2, 1'b0, -1);

      exec("halt", {5'b11011, 27'h0}, 0, 1'b0, -1);
      halted_hold("halt_hold", 1'b0);

      exec("illegal", {5'b11111, 27'h7ffffff}, 1, 1'b1, -1);
      halted_hold("illegal_hold", 1'b1);

      exec("final", {5'b10000, 4'd2, 4'd11, 4'd0, 15'h0}, 0, 1'b0, -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
